// File: rtl/fixed_point_multiplication2.sv
// Sequential unsigned Q(WIDTH-FRAC).FRAC shift-and-add multiplier, one partial product per clock.
// Define FXMUL_ROUND_EN for round-to-nearest (ties up); otherwise the product is truncated.
module fixed_point_multiplication2 #(
    parameter int WIDTH = 10,
    parameter int FRAC  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             start,
    output logic [WIDTH-1:0] P,
    output logic             ov,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state, w_next_state;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [WIDTH-1:0]   r_mcand, r_mplier;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_p;
    logic               r_ov, r_done;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0]   w_p;
    logic               w_ov;
    logic               w_last;

    assign w_sum     = {1'b0, r_hi} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    // Shifting the whole product keeps the discarded fraction bits out of the datapath.
    assign w_shifted = {r_hi, r_lo} >> FRAC;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef FXMUL_ROUND_EN
    logic           w_rnd;
    logic [WIDTH:0] w_rsum;
    if (FRAC > 0) begin : g_rnd
        assign w_rnd = r_lo[FRAC-1];
    end else begin : g_nornd
        assign w_rnd = 1'b0;
    end
    assign w_rsum = {1'b0, w_shifted[WIDTH-1:0]} + (WIDTH+1)'(w_rnd);
    assign w_p    = w_rsum[WIDTH-1:0];
    assign w_ov   = (|w_shifted[2*WIDTH-1:WIDTH]) | w_rsum[WIDTH];
`else
    assign w_p    = w_shifted[WIDTH-1:0];
    assign w_ov   = |w_shifted[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_CALC;
            S_CALC:  if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
            r_ov     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ld_a) r_a <= A;
            if (ld_b) r_b <= B;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= r_a;
                        r_mplier <= r_b;
                        r_hi     <= '0;
                        r_lo     <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    r_hi     <= w_sum[WIDTH:1];
                    r_lo     <= {w_sum[0], r_lo[WIDTH-1:1]};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_p    <= w_p;
                    r_ov   <= w_ov;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign P    = r_p;
    assign ov   = r_ov;
    assign done = r_done;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_fixed_point_multiplication2.sv
// Randomized bench for fixed_point_multiplication2 against an arithmetic reference model,
// plus directed cases with hand-computed products.
module tb_fixed_point_multiplication2;
    localparam int WIDTH = 10;
    localparam int FRAC  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ld_a = 1'b0, ld_b = 1'b0, start = 1'b0;
    logic [WIDTH-1:0] A = '0, B = '0;
    logic [WIDTH-1:0] P;
    logic             ov, busy, done;

    int checks = 0;
    int errors = 0;

    fixed_point_multiplication2 #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .A(A), .B(B),
        .start(start), .P(P), .ov(ov), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Product in Q format from plain integer arithmetic.
    function automatic void model_prod(input int a, input int b, output int p, output int o);
        int full, q, rnd;
        full = a * b;
        rnd  = 0;
`ifdef FXMUL_ROUND_EN
        if (FRAC > 0) rnd = (full >> (FRAC - 1)) & 1;
`endif
        q = (full >> FRAC) + rnd;
        p = q % (1 << WIDTH);
        o = (q >= (1 << WIDTH)) ? 1 : 0;
    endfunction

    // Reference model: an accepted start yields a result WIDTH+1 edges later.
    int ma, mb, opa, opb, bcnt, eP, eov, edone;
    always @(posedge clk) begin
        if (!rst) begin
            ma = 0; mb = 0; opa = 0; opb = 0; bcnt = 0; eP = 0; eov = 0; edone = 0;
        end else begin
            edone = 0;
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    model_prod(opa, opb, eP, eov);
                    edone = 1;
                end
            end else if (start) begin
                opa  = ma;
                opb  = mb;
                bcnt = WIDTH + 1;
            end
            if (ld_a) ma = A;
            if (ld_b) mb = B;
        end
        #1;
        chk("model_P", P, eP);
        chk("model_ov", ov, eov);
        chk("model_done", done, edone);
        chk("model_busy", busy, (bcnt > 0) ? 1 : 0);
    end

    task automatic go(input int a, input int b);
        @(negedge clk);
        ld_a = 1'b1; ld_b = 1'b1; A = WIDTH'(a); B = WIDTH'(b);
        @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0; start = 1'b1;
    endtask

    task automatic wait_done(output int p, output int o, output int bc, output int ed);
        bc = 0; ed = -1; p = -1; o = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ed = k; p = P; o = ov;
                break;
            end
            bc += busy;
        end
        if (ed < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic count_dones(input int n, output int nd);
        nd = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            nd += done;
        end
    endtask

    int p, o, bc, ed, nd;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_P", P, 0);
        chk("reset_ov", ov, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b1;

        go(56, 36);
        wait_done(p, o, bc, ed);
        chk("basic_P", p, 126);
        chk("basic_ov", o, 0);
        chk("basic_busy_cycles", bc, 11);
        chk("basic_latency", ed, 11);

        go(1023, 1023);
        wait_done(p, o, bc, ed);
        chk("ovf_P", p, 896);
        chk("ovf_ov", o, 1);

        go(1, 9);
        wait_done(p, o, bc, ed);
`ifdef FXMUL_ROUND_EN
        chk("round_P", p, 1);
`else
        chk("round_P", p, 0);
`endif
        chk("round_ov", o, 0);

        go(89, 184);
        wait_done(p, o, bc, ed);
`ifdef FXMUL_ROUND_EN
        chk("rcarry_P", p, 0);
        chk("rcarry_ov", o, 1);
`else
        chk("rcarry_P", p, 1023);
        chk("rcarry_ov", o, 0);
`endif

        // start during CALC is ignored
        go(56, 36);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        wait_done(p, o, bc, ed);
        chk("ignored_start_P", p, 126);
        count_dones(15, nd);
        chk("ignored_start_no_done", nd, 0);

        // ld_a mid-operation does not disturb the snapshot
        go(56, 36);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        ld_a = 1'b1; A = '0;
        @(negedge clk); ld_a = 1'b0;
        wait_done(p, o, bc, ed);
        chk("midload_P", p, 126);

        // ld_a together with start: old a used, new a seen by next start
        go(32, 48);
        ld_a = 1'b1; A = 10'd16;
        @(negedge clk); ld_a = 1'b0; start = 1'b0;
        wait_done(p, o, bc, ed);
        chk("same_edge_old_a", p, 96);
        // back-to-back: start in the done-high cycle
        start = 1'b1;
        wait_done(p, o, bc, ed);
        chk("same_edge_new_a", p, 48);
        chk("b2b_latency", ed, 11);

        // reset at iteration 5
        go(56, 36);
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_P", P, 0);
        chk("abort_ov", ov, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        count_dones(15, nd);
        chk("abort_no_done", nd, 0);
        go(56, 36);
        wait_done(p, o, bc, ed);
        chk("after_abort_P", p, 126);
        chk("after_abort_latency", ed, 11);

        // random traffic, checked each cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(3) == 0);
            ld_a  = ($urandom_range(7) == 0);
            ld_b  = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0:       A = '0;
                1:       A = '1;
                default: A = WIDTH'($urandom);
            endcase
            case ($urandom_range(3))
                0:       B = '0;
                1:       B = '1;
                default: B = WIDTH'($urandom);
            endcase
        end
        @(negedge clk);
        start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
        repeat (15) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fixed_point_multiplication2.md
# fixed_point_multiplication2

Sequential unsigned fixed-point multiplier using shift-and-add, one partial product per clock. It is the inverse datapath of the restoring fixed-point divider and shares its operand convention: 10-bit Q6.4 operands loaded into holding registers, then a start pulse. It sits beside the divider in the arithmetic unit and produces the Q6.4 product with an overflow flag and a one-cycle done pulse.

## Interface
- WIDTH, 10, operand and product width in bits
- FRAC, 4, fractional bits in operands and product (0 ≤ FRAC < WIDTH)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ld_a  in  1  load A into operand register a
- ld_b  in  1  load B into operand register b
- A  in  WIDTH  multiplicand, unsigned Q(WIDTH-FRAC).FRAC
- B  in  WIDTH  multiplier, same format
- start  in  1  begin a multiply; sampled only in IDLE
- P  out  WIDTH  product, registered, held until next done
- ov  out  1  product exceeded WIDTH bits; registered with P
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when P and ov are valid

## Operation
- The operand registers a and b load on any edge where ld_a or ld_b is high, in any state, and are independent of each other.
- FSM states:
  - IDLE: start=1 → CALC. On that edge:
    - snapshot a into mcand and b into mplier;
    - clear the 2·WIDTH-bit product register {hi,lo} and cnt.
  - CALC: one iteration per edge:
    - if mplier[0], {c,hi} = hi + mcand (WIDTH+1 bits), else {c,hi} = {0,hi};
    - shift {c,hi,lo} right by 1 and shift mplier right by 1;
    - cnt++.
    - When cnt == WIDTH-1 on an edge, that iteration completes and the next state is DONE.
  - DONE: one edge, then IDLE. On that edge:
    - P ← full[FRAC+WIDTH-1:FRAC], i.e. the low WIDTH bits of (a·b)>>FRAC (wraps on overflow);
    - ov ← |full[2·WIDTH-1:WIDTH+FRAC];
    - done ← 1.
- Outputs:
  - done is high only on the cycle following the DONE edge.
  - busy = (state != IDLE).
- start while busy is ignored, with no queueing.
- Changing ld_a/ld_b mid-operation does not affect the running result because of the snapshot.
- ld_a and start on the same edge: the operation uses the old a, and the new A is visible to the next start.
- Product of 0 gives P=0, ov=0.

## Timing
- Reset (rst low, async): state=IDLE, a=b=0, P=0, ov=0, done=0, busy=0, and all working registers are 0.
- Reset mid-operation aborts the operation, and no done is produced.
- Start sampled at edge 0. Iterations run at edges 1..WIDTH. The DONE edge is WIDTH+1, and done is high for the cycle after it.
- Latency is start edge to done high = WIDTH+1 edges (11 by default).
- busy is high from edge 0 to edge WIDTH+1. It is low in the same cycle done is high.
- The next start is accepted in the done-high cycle, giving back-to-back throughput of one result per WIDTH+2 cycles.

## Configuration
- FXMUL_ROUND_EN defined: round to nearest, ties up.
  - P ← full[FRAC+WIDTH-1:FRAC] + full[FRAC-1].
  - If the addition carries out of WIDTH bits, ov=1 and P is the wrapped value.
  - With FRAC=0 the rounding term is 0.
- FXMUL_ROUND_EN undefined: plain truncation as in Operation. No extra logic.

## Test plan
- Basic multiply: a=56 (3.5), b=36 (2.25), start → done after 11 edges with P=126 (7.875), ov=0. busy is high for exactly 11 cycles.
- Overflow: a=1023, b=1023 → P=896 (0x380), ov=1.
- Rounding: a=1, b=9.
  - Without FXMUL_ROUND_EN: P=0.
  - With FXMUL_ROUND_EN: P=1, ov=0.
- Rounding carry: a=89, b=184 (product 16376).
  - Truncate: P=1023, ov=0.
  - With FXMUL_ROUND_EN: P=0, ov=1.
- Protocol:
  - Start asserted during CALC is ignored.
  - ld_a with A=0 mid-operation does not change the result (56·36 still gives 126).
  - A start in the done-high cycle gives a second done 11 edges later.
- Reset: drop rst at iteration 5 → all outputs are 0 immediately, no done follows, and a subsequent start completes normally.
